scanner_link_rx: RTL and testbench

Serial link receiver for the scanner command/data interface. It is the receiving end of the clkOut/dataOut pair driven by a peer scanner. It synchronizes the peer's serial clock and data into the local clk domain and deserializes 8-bit LSB-first frames. It decodes command codes, captures the data payload that follows a DATA header, and presents a peer-status summary to the local scanner control FSM.

---
 rtl/scanner_link_rx.sv | 196 +++++++++++++++++++
 tb/tb_scanner_link_rx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scanner_link_rx.sv
// Receiving end of the peer scanner's serial clock/data pair.
// The peer's clock and data are brought into the clk domain, 8-bit LSB-first
// frames are deserialized, and command and payload bytes are decoded into
// pulses, held values and a peer-status summary.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_CMD  | next complete byte is decoded as a command code
// ST_DATA | a DATA header was seen; next complete byte is the payload
module scanner_link_rx #(
    parameter int         IDLE_TIMEOUT = 16,
    parameter logic [7:0] CMD_READY    = 8'd2,
    parameter logic [7:0] CMD_START    = 8'd3,
    parameter logic [7:0] CMD_FULL     = 8'd4,
    parameter logic [7:0] CMD_DATA     = 8'd7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clkIn,
    input  logic       dataIn,
    output logic       cmdValid,
    output logic [7:0] cmdCode,
    output logic       dataValid,
    output logic [7:0] dataByte,
    output logic       startScan,
    output logic [1:0] peerState,
    output logic       frameError,
    output logic       busy
);

    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic {
        ST_CMD  = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic          clk_sync1;
    logic          clk_sync2;
    logic          clk_sync3;
    logic          data_sync1;
    logic          data_sync2;

    // Only seven bits are kept: the eighth bit is taken straight from the
    // synchronizer when the byte completes, and the oldest bit would be
    // shifted out before it is ever used.
    logic [6:0]    shift;
    logic [2:0]    bit_count;
    logic [TW-1:0] tmo_cnt;

    logic          rise;
    logic          byte_done;
    logic          tmo_hit;
    logic [7:0]    rx_byte;

    logic          cmd_valid_d;
    logic          data_valid_d;
    logic          start_scan_d;
    logic          frame_error_d;
    logic [7:0]    cmd_code_d;
    logic [7:0]    data_byte_d;
    logic [1:0]    peer_state_d;

    assign rise      = clk_sync2 & ~clk_sync3;
    assign byte_done = rise && (bit_count == 3'd7);
    assign rx_byte   = {data_sync2, shift};
    assign busy      = (bit_count != 3'd0) || (state_q == ST_DATA);
    // A rise in the same cycle always beats the timeout.
    assign tmo_hit   = busy && !rise && (tmo_cnt == TW'(IDLE_TIMEOUT - 1));

    // Two-flop synchronizers, plus a third clkIn flop for rising-edge detect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync1  <= 1'b0;
            clk_sync2  <= 1'b0;
            clk_sync3  <= 1'b0;
            data_sync1 <= 1'b0;
            data_sync2 <= 1'b0;
        end else begin
            clk_sync1  <= clkIn;
            clk_sync2  <= clk_sync1;
            clk_sync3  <= clk_sync2;
            data_sync1 <= dataIn;
            data_sync2 <= data_sync1;
        end
    end

    // Deserializer: shift in at the MSB end on each rise; a timeout drops the partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift     <= '0;
            bit_count <= 3'd0;
        end else if (rise) begin
            shift     <= {data_sync2, shift[6:1]};
            bit_count <= bit_count + 3'd1;
        end else if (tmo_hit) begin
            shift     <= '0;
            bit_count <= 3'd0;
        end
    end

    // Mid-frame idle timer: cleared by a rise, held at zero while idle, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (rise || !busy) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TW'(IDLE_TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Next-state and output decode for completed bytes and timeouts.
    always_comb begin
        state_d       = state_q;
        cmd_valid_d   = 1'b0;
        data_valid_d  = 1'b0;
        start_scan_d  = 1'b0;
        frame_error_d = 1'b0;
        cmd_code_d    = cmdCode;
        data_byte_d   = dataByte;
        peer_state_d  = peerState;

        if (byte_done) begin
            case (state_q)
                ST_CMD: begin
                    case (rx_byte)
                        CMD_READY: begin
                            cmd_valid_d  = 1'b1;
                            cmd_code_d   = rx_byte;
                            peer_state_d = 2'b01;
                        end
                        CMD_START: begin
                            cmd_valid_d  = 1'b1;
                            start_scan_d = 1'b1;
                            cmd_code_d   = rx_byte;
                            peer_state_d = 2'b10;
                        end
                        CMD_FULL: begin
                            cmd_valid_d  = 1'b1;
                            cmd_code_d   = rx_byte;
                            peer_state_d = 2'b11;
                        end
                        CMD_DATA: begin
                            cmd_valid_d = 1'b1;
                            cmd_code_d  = rx_byte;
                            state_d     = ST_DATA;
                        end
                        default: begin
                            frame_error_d = 1'b1;
                        end
                    endcase
                end
                ST_DATA: begin
                    data_valid_d = 1'b1;
                    data_byte_d  = rx_byte;
                    peer_state_d = 2'b00;
                    state_d      = ST_CMD;
                end
                default: begin
                    state_d = ST_CMD;
                end
            endcase
        end else if (tmo_hit) begin
            frame_error_d = 1'b1;
            state_d       = ST_CMD;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_CMD;
            cmdValid   <= 1'b0;
            dataValid  <= 1'b0;
            startScan  <= 1'b0;
            frameError <= 1'b0;
            cmdCode    <= 8'd0;
            dataByte   <= 8'd0;
            peerState  <= 2'b00;
        end else begin
            state_q    <= state_d;
            cmdValid   <= cmd_valid_d;
            dataValid  <= data_valid_d;
            startScan  <= start_scan_d;
            frameError <= frame_error_d;
            cmdCode    <= cmd_code_d;
            dataByte   <= data_byte_d;
            peerState  <= peer_state_d;
        end
    end

endmodule

// File: tb/tb_scanner_link_rx.sv
// Bench for scanner_link_rx: directed scenarios followed by random frames,
// compared against an event-level model of the command protocol.
module tb_scanner_link_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clkIn = 1'b0;
    logic       dataIn = 1'b0;
    logic       cmdValid;
    logic [7:0] cmdCode;
    logic       dataValid;
    logic [7:0] dataByte;
    logic       startScan;
    logic [1:0] peerState;
    logic       frameError;
    logic       busy;

    scanner_link_rx dut (
        .clk       (clk),
        .rst       (rst),
        .clkIn     (clkIn),
        .dataIn    (dataIn),
        .cmdValid  (cmdValid),
        .cmdCode   (cmdCode),
        .dataValid (dataValid),
        .dataByte  (dataByte),
        .startScan (startScan),
        .peerState (peerState),
        .frameError(frameError),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // kind: 1 = command, 2 = payload, 3 = frame error
    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  val;
        logic [1:0]  peer;
        logic        start;
        logic [31:0] cyc;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int viol = 0;
    int rise_cyc = 0;

    logic [7:0] m_code = 8'd0;
    logic [7:0] m_byte = 8'd0;
    logic [1:0] m_peer = 2'd0;
    bit         m_in_data = 1'b0;

    logic prev_c = 1'b0, prev_d = 1'b0, prev_e = 1'b0, prev_s = 1'b0;

    // Free-running cycle counter used to time events.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every pulse and count violations of the pulse rules.
    always @(negedge clk) begin
        if ((int'(cmdValid) + int'(dataValid) + int'(frameError)) > 1) viol++;
        if (startScan && !(cmdValid && cmdCode == 8'd3)) viol++;
        if ((cmdValid && prev_c) || (dataValid && prev_d) ||
            (frameError && prev_e) || (startScan && prev_s)) viol++;
        prev_c = cmdValid;
        prev_d = dataValid;
        prev_e = frameError;
        prev_s = startScan;
        if (cmdValid)
            obs_q.push_back('{kind: 2'd1, val: cmdCode, peer: peerState, start: startScan, cyc: cyc});
        if (dataValid)
            obs_q.push_back('{kind: 2'd2, val: dataByte, peer: peerState, start: startScan, cyc: cyc});
        if (frameError)
            obs_q.push_back('{kind: 2'd3, val: cmdCode, peer: peerState, start: startScan, cyc: cyc});
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Protocol model: what a completed byte should produce.
    task automatic model_byte(input logic [7:0] b);
        if (m_in_data) begin
            m_byte    = b;
            m_peer    = 2'd0;
            m_in_data = 1'b0;
            exp_q.push_back('{kind: 2'd2, val: b, peer: 2'd0, start: 1'b0, cyc: 0});
        end else if (b == 8'd2 || b == 8'd3 || b == 8'd4) begin
            m_code = b;
            m_peer = 2'(b - 8'd1);
            exp_q.push_back('{kind: 2'd1, val: b, peer: m_peer, start: (b == 8'd3), cyc: 0});
        end else if (b == 8'd7) begin
            m_code    = b;
            m_in_data = 1'b1;
            exp_q.push_back('{kind: 2'd1, val: b, peer: m_peer, start: 1'b0, cyc: 0});
        end else begin
            exp_q.push_back('{kind: 2'd3, val: m_code, peer: m_peer, start: 1'b0, cyc: 0});
        end
    endtask

    // Called just after a falling clk edge; leaves clkIn high.
    task automatic send_bit(input logic b, input int half);
        clkIn  = 1'b0;
        dataIn = b;
        repeat (half) @(negedge clk);
        clkIn    = 1'b1;
        rise_cyc = cyc;
        repeat (half) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int half);
        for (int i = 0; i < 8; i++) send_bit(b[i], half);
        model_byte(b);
    endtask

    task automatic idle(input int n);
        clkIn = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_events(input string tag);
        ev_t o;
        ev_t e;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_kind"}, o.kind, e.kind);
            chk({tag, "_val"}, o.val, e.val);
            chk({tag, "_peer"}, o.peer, e.peer);
            chk({tag, "_start"}, o.start, e.start);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_zero(input string tag);
        chk(tag, {cmdValid, cmdCode, dataValid, dataByte, startScan, peerState, frameError, busy}, 32'd0);
    endtask

    initial begin
        int exp_cyc;
        int r;
        int half;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        rst = 1'b1;
        idle(3);

        // 1: START command
        send_byte(8'h03, 4);
        idle(6);
        check_events("start_cmd");
        chk("start_peer", peerState, 2'b10);
        chk("start_busy", busy, 1'b0);

        // 2: DATA header then payload
        send_byte(8'h07, 4);
        idle(3);
        chk("hdr_busy", busy, 1'b1);
        send_byte(8'h09, 4);
        idle(6);
        check_events("data_frame");
        chk("data_byte", dataByte, 8'h09);
        chk("data_peer", peerState, 2'b00);
        chk("data_busy", busy, 1'b0);

        // 3: unknown command
        send_byte(8'h03, 4);
        send_byte(8'h05, 4);
        idle(6);
        check_events("unknown_cmd");
        chk("unknown_code_kept", cmdCode, m_code);
        chk("unknown_peer_kept", peerState, m_peer);

        // Idle line in CMD never times out
        idle(40);
        check_events("idle_quiet");

        // 4: partial frame timeout
        for (int i = 0; i < 4; i++) send_bit(1'b1, 4);
        exp_cyc = rise_cyc + 19;
        idle(24);
        chk("tmo_seen", obs_q.size() > 0, 1'b1);
        if (obs_q.size() > 0) chk("tmo_cycle", obs_q[0].cyc, exp_cyc);
        exp_q.push_back('{kind: 2'd3, val: m_code, peer: m_peer, start: 1'b0, cyc: 0});
        check_events("timeout");
        chk("tmo_busy", busy, 1'b0);
        send_byte(8'h04, 4);
        idle(6);
        check_events("after_tmo");
        chk("after_tmo_peer", peerState, 2'b11);

        // 5: asynchronous reset mid-frame
        for (int i = 0; i < 5; i++) send_bit(b_of(8'h02, i), 4);
        clkIn = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_code = 8'd0;
        m_byte = 8'd0;
        m_peer = 2'd0;
        m_in_data = 1'b0;
        obs_q.delete();
        idle(3);
        send_byte(8'h02, 4);
        idle(6);
        check_events("post_reset");
        chk("post_reset_peer", peerState, 2'b01);

        // 6: back-to-back commands at the minimum half-period
        send_byte(8'h02, 3);
        send_byte(8'h03, 3);
        send_byte(8'h04, 3);
        idle(6);
        check_events("back2back");
        chk("b2b_peer", peerState, 2'b11);

        // Random frames
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: b = 8'd2;
                1: b = 8'd3;
                2: b = 8'd4;
                3: b = 8'd7;
                default: b = 8'($urandom);
            endcase
            half = $urandom_range(3, 6);
            send_byte(b, half);
            if (!m_in_data) idle($urandom_range(0, 8));
        end
        if (m_in_data) send_byte(8'($urandom), 4);
        idle(6);
        check_events("random");
        chk("random_code", cmdCode, m_code);
        chk("random_byte", dataByte, m_byte);
        chk("random_peer", peerState, m_peer);
        chk("random_busy", busy, 1'b0);

        chk("pulse_rules", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic b_of(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule
